// File: rtl/fixed_div_if.sv
// Handshake and data bundle for the sequential fixed-point divider.
// The requester (master) drives start and the operands; the divider (slave)
// returns the registered quotient, busy/done handshake and status flags.
interface fixed_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] QUOTIENT;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, A, B,
        input  QUOTIENT, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, A, B,
        output QUOTIENT, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/fixed_div.sv
// Unsigned fixed-point divider, restoring shift-subtract.
// Computes floor((A << FRAC) / B) one quotient bit per clock, MSB first,
// over WIDTH+FRAC iterations. Latency is constant for every operand pair:
// B = 0 and overflow cases run the full iteration count and are only
// classified when the result is written back.
module fixed_div #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic        clk,
    input  logic        reset,
    fixed_div_if.slave  bus
);
    localparam int ITER  = WIDTH + FRAC;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Registered state
    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [ITER-1:0]    dq_r;       // dividend bits shift out of the top, quotient bits shift in at the bottom
    logic [WIDTH-1:0]   rem_r;      // partial remainder, always < divisor
    logic [WIDTH-1:0]   b_r;        // divisor latched at start
    logic [WIDTH-1:0]   quot_r;
    logic               dbz_r;
    logic               ovf_r;
    logic               busy_r;
    logic               done_r;

    // Next-state values
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_next_s;
    logic [ITER-1:0]    dq_next_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic [WIDTH-1:0]   b_next_s;
    logic [WIDTH-1:0]   quot_next_s;
    logic               dbz_next_s;
    logic               ovf_next_s;
    logic               busy_next_s;
    logic               done_next_s;

    // Datapath helpers
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH-1:0]   rem_sub_s;
    logic               ge_s;
    logic               b_zero_s;
    logic               q_high_s;

    // One restoring step: bring down the next dividend bit and trial-subtract.
    always_comb begin
        rem_sh_s  = {rem_r, dq_r[ITER-1]};
        ge_s      = (rem_sh_s >= {1'b0, b_r});
        // The difference is below the divisor whenever it is kept, so the
        // low WIDTH bits carry the whole remainder.
        rem_sub_s = rem_sh_s[WIDTH-1:0] - b_r;
        b_zero_s  = (b_r == {WIDTH{1'b0}});
        // Any quotient bit at or above 2^WIDTH means the result does not fit.
        q_high_s  = ((dq_r >> WIDTH) != {ITER{1'b0}});
    end

    // Next-state and output logic for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        dq_next_s    = dq_r;
        rem_next_s   = rem_r;
        b_next_s     = b_r;
        quot_next_s  = quot_r;
        dbz_next_s   = dbz_r;
        ovf_next_s   = ovf_r;
        busy_next_s  = busy_r;
        done_next_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    dq_next_s    = ITER'(bus.A) << FRAC;
                    b_next_s     = bus.B;
                    rem_next_s   = {WIDTH{1'b0}};
                    cnt_next_s   = {CNT_W{1'b0}};
                    busy_next_s  = 1'b1;
                    state_next_s = CALC;
                end else begin
                    busy_next_s  = 1'b0;
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                rem_next_s = ge_s ? rem_sub_s : rem_sh_s[WIDTH-1:0];
                dq_next_s  = {dq_r[ITER-2:0], ge_s};
                cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_W'(ITER - 1)) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE: begin
                // Divide-by-zero takes precedence; it never also reports overflow.
                dbz_next_s = b_zero_s;
                ovf_next_s = !b_zero_s && q_high_s;
                if (b_zero_s || q_high_s) begin
                    quot_next_s = {WIDTH{1'b1}};
                end else begin
                    quot_next_s = dq_r[WIDTH-1:0];
                end
                done_next_s  = 1'b1;
                busy_next_s  = 1'b0;
                state_next_s = IDLE;
            end
            default: begin
                busy_next_s  = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            dq_r    <= {ITER{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            quot_r  <= {WIDTH{1'b0}};
            dbz_r   <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            dq_r    <= dq_next_s;
            rem_r   <= rem_next_s;
            b_r     <= b_next_s;
            quot_r  <= quot_next_s;
            dbz_r   <= dbz_next_s;
            ovf_r   <= ovf_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    assign bus.QUOTIENT    = quot_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;
endmodule

// File: tb/tb_fixed_div.sv
// Self-checking bench for fixed_div (Q16.16 defaults): directed vector
// table, randomized operands against an arithmetic reference, and
// hand-written sequences for ignored starts, reset abort and back-to-back.
module tb_fixed_div;
    localparam int LAT = 49;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fixed_div_if #(.WIDTH(32)) bus ();

    fixed_div #(.WIDTH(32), .FRAC(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        dbz;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact quotient of the scaled dividend using wide arithmetic.
    function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        if (b == 32'd0) return {32'hFFFF_FFFF, 1'b1, 1'b0};
        full = ({32'd0, a} * 64'd65536) / {32'd0, b};
        if (full > 64'h0000_0000_FFFF_FFFF) return {32'hFFFF_FFFF, 1'b0, 1'b1};
        return {full[31:0], 1'b0, 1'b0};
    endfunction

    // Waits for done after an accepted start; busy must stay high until then.
    task automatic wait_done(output int lat, output bit busy_ok, output bit seen);
        lat = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && lat < 70) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) seen = 1'b1;
            else if (!bus.busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q_e, input logic dbz_e, input logic ovf_e);
        int lat; bit busy_ok; bit seen;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
        wait_done(lat, busy_ok, seen);
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(LAT));
        check({tag, " busy_during"}, 32'(busy_ok), 32'd1);
        check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, " quotient"}, bus.QUOTIENT, q_e);
        check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(dbz_e));
        check({tag, " overflow"}, 32'(bus.overflow), 32'(ovf_e));
        bus.A = ~a; bus.B = ~b;
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
        check({tag, " quotient_hold"}, bus.QUOTIENT, q_e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [33:0] exp_r;
        int lat, n_done, first_done, second_done;
        bit busy_ok, seen, busy_seen;

        vecs[0]  = '{32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0};
        vecs[1]  = '{32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0};
        vecs[2]  = '{32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3]  = '{32'hFFFF_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1};
        vecs[4]  = '{32'h0001_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1};
        vecs[5]  = '{32'h0000_FFFF, 32'h0000_0001, 32'hFFFF_0000, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 1'b0};
        vecs[8]  = '{32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0};
        vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[10] = '{32'h0005_0000, 32'h0001_0000, 32'h0005_0000, 1'b0, 1'b0};
        vecs[11] = '{32'h0000_0007, 32'h0000_0002, 32'h0003_8000, 1'b0, 1'b0};

        bus.start = 1'b0; bus.A = 32'd0; bus.B = 32'd0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("reset quotient", bus.QUOTIENT, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        check("reset overflow", 32'(bus.overflow), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dbz, vecs[i].ovf);
        end

        // Randomized operands, biased toward small divisors and zero
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 4)
                0: rb = rb >> $urandom_range(0, 31);
                1: ra = ra >> $urandom_range(0, 31);
                2: rb = 32'($urandom_range(0, 3));
                default: ;
            endcase
            exp_r = ref_div(ra, rb);
            run_div($sformatf("rand%0d", i), ra, rb, exp_r[33:2], exp_r[1], exp_r[0]);
        end

        // Operand changes and a second start during CALC are ignored
        @(negedge clk);
        bus.A = 32'h0003_0000; bus.B = 32'h0002_0000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        bus.A = 32'hFFFF_0000; bus.B = 32'h0000_0001; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("ignore busy_kept", 32'(bus.busy), 32'd1);
        wait_done(lat, busy_ok, seen);
        check("ignore done_seen", 32'(seen), 32'd1);
        check("ignore latency", 32'(lat + 11), 32'(LAT));
        check("ignore quotient", bus.QUOTIENT, 32'h0001_8000);
        check("ignore overflow", 32'(bus.overflow), 32'd0);
        @(posedge clk); #1;

        // Reset mid-division: set nonzero status first so clearing is visible
        run_div("pre_reset", 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(negedge clk);
        bus.A = 32'h0003_0000; bus.B = 32'h0002_0000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        bus.A = 32'h0000_1111; bus.B = 32'h0000_0003; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("abort busy_before_reset", 32'(bus.busy), 32'd1);
        check("abort dbz_held", 32'(bus.div_by_zero), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort quotient", bus.QUOTIENT, 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort div_by_zero", 32'(bus.div_by_zero), 32'd0);
        check("abort overflow", 32'(bus.overflow), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        n_done = 0; busy_seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (bus.done) n_done++;
            if (bus.busy) busy_seen = 1'b1;
        end
        check("abort no_done", 32'(n_done), 32'd0);
        check("abort no_busy", 32'(busy_seen), 32'd0);
        run_div("post_reset", 32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0);

        // Back-to-back: start held high for 120 cycles
        @(negedge clk);
        bus.A = 32'h0005_0000; bus.B = 32'h0001_0000; bus.start = 1'b1;
        n_done = 0; first_done = -1; second_done = -1;
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                n_done++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
                check($sformatf("b2b quotient@%0d", c), bus.QUOTIENT, 32'h0005_0000);
            end
        end
        bus.start = 1'b0;
        check("b2b pulse_count", 32'(n_done), 32'd2);
        check("b2b first_done", 32'(first_done), 32'(LAT + 1));
        check("b2b spacing", 32'(second_done - first_done), 32'd50);
        repeat (40) begin @(posedge clk); #1; end
        check("b2b drain_quotient", bus.QUOTIENT, 32'h0005_0000);
        check("b2b drain_idle", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
